// File: rtl/fq_tuner.sv
// Frequency tuning stage: applies scaled dial detents to a clamped frequency
// register, then converts the frequency to an NCO tuning word with a serial
// shift-add multiplier. Each new word is announced with a one-cycle strobe.
module fq_tuner #(
  parameter int FREQ_W  = 32,
  parameter int F_INIT  = 7_100_000,
  parameter int F_MIN   = 100_000,
  parameter int F_MAX   = 30_000_000,
  parameter int TW_K    = 17_592_186,
  parameter int TW_FRAC = 16
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic [7:0]        fq_inc,
  input  logic              in_valid,
  input  logic              step_btn,
  output logic [FREQ_W-1:0] freq_hz,
  output logic [2:0]        step_idx,
  output logic [31:0]       tw,
  output logic              tw_valid,
  output logic              busy
);

  localparam int SW    = FREQ_W + 2;
  localparam int KW    = 25;
  localparam int ACC_W = FREQ_W + KW;
  localparam int CW    = $clog2(FREQ_W);

  localparam logic signed [SW-1:0] MINV  = SW'(F_MIN);
  localparam logic signed [SW-1:0] MAXV  = SW'(F_MAX);
  localparam logic [ACC_W-1:0]     K_EXT = ACC_W'(TW_K);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_MUL, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_vld_prev;
  logic [FREQ_W-1:0]       r_freq;
  logic [2:0]              r_step;
  logic [2:0]              r_step_lat;
  logic signed [7:0]       r_inc;
  logic signed [7:0]       r_pend;
  logic [2:0]              r_pend_step;
  logic [31:0]             r_tw;
  logic                    r_tw_vld;
  logic [FREQ_W-1:0]       r_mplr;
  logic [ACC_W-1:0]        r_mcand;
  logic [ACC_W-1:0]        r_acc;
  logic [CW-1:0]           r_cnt;

  logic                    w_req;
  logic                    w_inc_nz;
  logic signed [7:0]       w_inc;
  logic signed [SW-1:0]    w_inc_ext;
  logic signed [SW-1:0]    w_delta;
  logic signed [SW-1:0]    w_sum;
  logic [FREQ_W-1:0]       w_new_freq;
  logic                    w_unused;

  // Step size in Hz for a given step index, in the signed update domain.
  function automatic logic signed [SW-1:0] step_val(input logic [2:0] idx);
    case (idx)
      3'd0:    return SW'(1);
      3'd1:    return SW'(10);
      3'd2:    return SW'(100);
      3'd3:    return SW'(1_000);
      3'd4:    return SW'(10_000);
      3'd5:    return SW'(100_000);
      default: return SW'(1);
    endcase
  endfunction

  // Clamp a signed candidate frequency into [F_MIN, F_MAX].
  function automatic logic [FREQ_W-1:0] clamp_freq(input logic signed [SW-1:0] s);
    if (s < MINV)      return FREQ_W'(F_MIN);
    else if (s > MAXV) return FREQ_W'(F_MAX);
    else               return s[FREQ_W-1:0];
  endfunction

  // Saturating add of two detent counts into the 8-bit signed range.
  function automatic logic signed [7:0] sat_add8(input logic signed [7:0] a,
                                                 input logic signed [7:0] b);
    logic signed [8:0] s;
    s = 9'(a) + 9'(b);
    if (s > 9'sd127)       return 8'sd127;
    else if (s < -9'sd128) return -8'sd128;
    else                   return s[7:0];
  endfunction

  assign w_inc      = $signed(fq_inc);
  assign w_inc_nz   = (fq_inc != 8'd0);
  assign w_req      = in_valid & ~r_vld_prev;
  assign w_inc_ext  = SW'(r_inc);
  assign w_delta    = w_inc_ext * step_val(r_step_lat);
  assign w_sum      = $signed({2'b00, r_freq}) + w_delta;
  assign w_new_freq = clamp_freq(w_sum);

  // Accumulator bits outside the tuning-word window only feed carries.
  assign w_unused = &{1'b0, r_acc[ACC_W-1:TW_FRAC+32], r_acc[TW_FRAC-1:0]};

  // State register; reset restarts with the init pass in APPLY.
  always_ff @(posedge aclk) begin
    if (reset) r_state <= S_APPLY;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if ((r_pend != 8'sd0) || (w_req && w_inc_nz)) w_state_nxt = S_APPLY;
      S_APPLY: w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Step index: advances on each button pulse, wrapping after 100 kHz.
  always_ff @(posedge aclk) begin
    if (reset)         r_step <= 3'd3;
    else if (step_btn) r_step <= (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
  end

  // Request capture, pending merge, frequency update and tuning-word output.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_vld_prev  <= 1'b0;
      r_freq      <= FREQ_W'(F_INIT);
      r_inc       <= 8'sd0;
      r_step_lat  <= 3'd3;
      r_pend      <= 8'sd0;
      r_pend_step <= 3'd3;
      r_tw        <= 32'd0;
      r_tw_vld    <= 1'b0;
    end else begin
      r_vld_prev <= in_valid;
      r_tw_vld   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pend != 8'sd0) begin
            // Pending work goes first; a coincident fresh request re-fills it.
            r_inc      <= r_pend;
            r_step_lat <= r_pend_step;
            if (w_req && w_inc_nz) begin
              r_pend      <= w_inc;
              r_pend_step <= r_step;
            end else begin
              r_pend <= 8'sd0;
            end
          end else if (w_req && w_inc_nz) begin
            r_inc      <= w_inc;
            r_step_lat <= r_step;
          end
        end
        S_APPLY: r_freq <= w_new_freq;
        S_DONE: begin
          r_tw     <= r_acc[TW_FRAC+31:TW_FRAC];
          r_tw_vld <= 1'b1;
        end
        default: ;
      endcase
      if ((r_state != S_IDLE) && w_req && w_inc_nz) begin
        r_pend      <= sat_add8(r_pend, w_inc);
        r_pend_step <= r_step;
      end
    end
  end

  // Serial multiplier: one multiplier bit per cycle, LSB first.
  always_ff @(posedge aclk) begin
    case (r_state)
      S_APPLY: begin
        r_mplr  <= w_new_freq;
        r_mcand <= K_EXT;
        r_acc   <= '0;
        r_cnt   <= CW'(FREQ_W - 1);
      end
      S_MUL: begin
        r_acc   <= r_acc + (r_mplr[0] ? r_mcand : '0);
        r_mcand <= r_mcand << 1;
        r_mplr  <= r_mplr >> 1;
        r_cnt   <= r_cnt - 1'b1;
      end
      default: ;
    endcase
  end

  assign freq_hz  = r_freq;
  assign step_idx = r_step;
  assign tw       = r_tw;
  assign tw_valid = r_tw_vld;

endmodule

// File: tb/tb_fq_tuner.sv
// Bench for fq_tuner: directed scenarios plus randomized requests, checked
// against a plain-arithmetic model of frequency, step and tuning word.
`timescale 1ns/1ps
module tb_fq_tuner;
  localparam int     FREQ_W = 32;
  localparam longint F_INIT = 7_100_000;
  localparam longint F_MIN  = 100_000;
  localparam longint F_MAX  = 30_000_000;
  localparam longint TW_K   = 17_592_186;
  localparam int     LAT    = FREQ_W + 2;

  logic              aclk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        fq_inc = 8'd0;
  logic              in_valid = 1'b0;
  logic              step_btn = 1'b0;
  logic [FREQ_W-1:0] freq_hz;
  logic [2:0]        step_idx;
  logic [31:0]       tw;
  logic              tw_valid;
  logic              busy;

  int     total = 0;
  int     bad = 0;
  longint m_freq = F_INIT;
  int     m_step = 3;

  fq_tuner dut (
    .aclk(aclk), .reset(reset), .fq_inc(fq_inc), .in_valid(in_valid),
    .step_btn(step_btn), .freq_hz(freq_hz), .step_idx(step_idx),
    .tw(tw), .tw_valid(tw_valid), .busy(busy)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic longint step_hz(input int idx);
    longint t[6] = '{1, 10, 100, 1_000, 10_000, 100_000};
    return t[idx];
  endfunction

  function automatic longint clampf(input longint f);
    if (f < F_MIN) return F_MIN;
    if (f > F_MAX) return F_MAX;
    return f;
  endfunction

  function automatic logic [31:0] tw_of(input longint f);
    return 32'((f * TW_K) >> 16);
  endfunction

  task automatic press(input string tag);
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    m_step = (m_step + 1) % 6;
    total++;
    if (step_idx !== 3'(m_step)) begin
      bad++;
      $display("FAIL %s step_idx: got %0d want %0d", tag, step_idx, m_step);
    end
  endtask

  task automatic do_req(input logic signed [7:0] inc, input string tag);
    longint exp_f;
    int     n;
    exp_f = (inc == 0) ? m_freq : clampf(m_freq + longint'(inc) * step_hz(m_step));
    fq_inc = inc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    total++;
    if (freq_hz !== 32'(exp_f)) begin
      bad++;
      $display("FAIL %s freq: got %0d want %0d", tag, freq_hz, exp_f);
    end
    m_freq = exp_f;
    n = 1;
    while (!tw_valid && n < 80) begin
      tick();
      n++;
    end
    if (inc == 0) begin
      total++;
      if (tw_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s zero-inc: got tw_valid=%b busy=%b want 0 0", tag, tw_valid, busy);
      end
    end else begin
      total++;
      if (n !== LAT) begin
        bad++;
        $display("FAIL %s latency: got %0d want %0d", tag, n, LAT);
      end
      total++;
      if (tw !== tw_of(exp_f)) begin
        bad++;
        $display("FAIL %s tw: got %0d want %0d", tag, tw, tw_of(exp_f));
      end
      tick();
      total++;
      if (tw_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s strobe width: got %b want 0", tag, tw_valid);
      end
    end
  endtask

  task automatic reset_and_init(input string tag);
    int n;
    m_freq = F_INIT;
    m_step = 3;
    total++;
    if (freq_hz !== 32'(F_INIT) || step_idx !== 3'd3) begin
      bad++;
      $display("FAIL %s reset regs: got freq=%0d step=%0d want %0d 3", tag, freq_hz, step_idx, F_INIT);
    end
    total++;
    if (tw !== 32'd0 || tw_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s reset outs: got tw=%0d tw_valid=%b busy=%b want 0 0 1", tag, tw, tw_valid, busy);
    end
    n = 0;
    while (!tw_valid && n < 80) begin
      tick();
      n++;
    end
    total++;
    if (n !== LAT) begin
      bad++;
      $display("FAIL %s init latency: got %0d want %0d", tag, n, LAT);
    end
    total++;
    if (tw !== tw_of(F_INIT) || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s init tw: got %0d busy=%b want %0d 0", tag, tw, busy, tw_of(F_INIT));
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    reset_and_init("reset");
  endtask

  task automatic test_basic_hold();
    longint exp_f;
    int     strobes;
    int     first_at;
    exp_f = clampf(m_freq + 3 * step_hz(m_step));
    fq_inc = 8'd3;
    in_valid = 1'b1;
    tick();
    tick();
    total++;
    if (freq_hz !== 32'(exp_f) || exp_f != 7_103_000) begin
      bad++;
      $display("FAIL basic freq: got %0d want 7103000", freq_hz);
    end
    strobes = 0;
    first_at = 0;
    for (int i = 2; i < 110; i++) begin
      tick();
      if (tw_valid) begin
        if (strobes == 0) first_at = i;
        strobes++;
      end
    end
    in_valid = 1'b0;
    tick();
    m_freq = exp_f;
    total++;
    if (strobes !== 1 || first_at !== LAT) begin
      bad++;
      $display("FAIL basic hold strobes: got %0d at %0d want 1 at %0d", strobes, first_at, LAT);
    end
    total++;
    if (tw !== tw_of(exp_f)) begin
      bad++;
      $display("FAIL basic tw: got %0d want %0d", tw, tw_of(exp_f));
    end
  endtask

  task automatic test_clamp();
    int k;
    press("clamp step");
    press("clamp step");
    do_req(-8'sd128, "clamp low");
    total++;
    if (freq_hz !== 32'd100_000) begin
      bad++;
      $display("FAIL clamp low value: got %0d want 100000", freq_hz);
    end
    k = 0;
    while (m_freq != F_MAX && k < 10) begin
      do_req(8'sd127, "clamp up");
      k++;
    end
    do_req(8'sd127, "clamp hold");
    total++;
    if (freq_hz !== 32'd30_000_000) begin
      bad++;
      $display("FAIL clamp high value: got %0d want 30000000", freq_hz);
    end
  endtask

  task automatic test_one_mhz();
    do_req(-8'sd127, "1mhz down");
    do_req(-8'sd127, "1mhz down");
    do_req(-8'sd128, "1mhz floor");
    do_req(8'sd9, "1mhz set");
    total++;
    if (freq_hz !== 32'd1_000_000 || tw !== 32'h0FFF_FFFF) begin
      bad++;
      $display("FAIL 1mhz tw: got freq=%0d tw=%0d want 1000000 268435455", freq_hz, tw);
    end
  endtask

  task automatic test_pending();
    int          strobes;
    logic [31:0] first_tw;
    longint      f1;
    longint      f2;
    while (m_step != 1) press("pend step");
    f1 = clampf(m_freq + 5 * 10);
    f2 = clampf(f1 + 127 * 10);
    fq_inc = 8'd5;
    in_valid = 1'b1;
    tick();
    strobes = 0;
    first_tw = 32'd0;
    for (int i = 0; i < 120; i++) begin
      if (i == 4 || i == 8) begin
        fq_inc = 8'd100;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (tw_valid) begin
        if (strobes == 0) first_tw = tw;
        strobes++;
      end
    end
    m_freq = f2;
    total++;
    if (strobes !== 2) begin
      bad++;
      $display("FAIL pending strobes: got %0d want 2", strobes);
    end
    total++;
    if (first_tw !== tw_of(f1)) begin
      bad++;
      $display("FAIL pending first tw: got %0d want %0d", first_tw, tw_of(f1));
    end
    total++;
    if (freq_hz !== 32'(f2) || tw !== tw_of(f2)) begin
      bad++;
      $display("FAIL pending final: got freq=%0d tw=%0d want %0d %0d", freq_hz, tw, f2, tw_of(f2));
    end
  endtask

  task automatic test_step_same_cycle();
    longint exp_f;
    int     n;
    exp_f = clampf(m_freq + 7 * step_hz(m_step));
    step_btn = 1'b1;
    fq_inc = 8'd7;
    in_valid = 1'b1;
    tick();
    step_btn = 1'b0;
    in_valid = 1'b0;
    m_step = (m_step + 1) % 6;
    tick();
    total++;
    if (freq_hz !== 32'(exp_f) || step_idx !== 3'(m_step)) begin
      bad++;
      $display("FAIL same-cycle: got freq=%0d step=%0d want %0d %0d", freq_hz, step_idx, exp_f, m_step);
    end
    m_freq = exp_f;
    n = 1;
    while (!tw_valid && n < 80) begin
      tick();
      n++;
    end
    total++;
    if (tw !== tw_of(exp_f) || n !== LAT) begin
      bad++;
      $display("FAIL same-cycle tw: got %0d at %0d want %0d at %0d", tw, n, tw_of(exp_f), LAT);
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] r;
    for (int it = 0; it < 25; it++) begin
      for (int p = $urandom_range(0, 2); p > 0; p--) press("rand step");
      r = 8'($urandom);
      if ($urandom_range(0, 4) == 0) r = 8'd0;
      do_req($signed(r), "rand");
    end
  endtask

  task automatic test_step_wrap_and_reset_mid();
    int seq[7] = '{4, 5, 0, 1, 2, 3, 4};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_and_init("reset2");
    for (int i = 0; i < 7; i++) begin
      press("wrap");
      total++;
      if (step_idx !== 3'(seq[i])) begin
        bad++;
        $display("FAIL wrap seq[%0d]: got %0d want %0d", i, step_idx, seq[i]);
      end
    end
    fq_inc = 8'd50;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_and_init("reset mid");
  endtask

  initial begin
    test_reset();
    test_basic_hold();
    do_req(8'sd0, "zero inc");
    test_clamp();
    test_one_mhz();
    test_pending();
    test_step_same_cycle();
    test_random();
    test_step_wrap_and_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fq_tuner.md
# fq_tuner

Frequency tuning stage that sits directly downstream of the frequency dial. It consumes the signed detent count (`fq_inc`) published by the dial at each poll and scales it by a user-selectable step. It then accumulates the result into a clamped frequency register in Hz. Finally it converts that frequency into a 32-bit NCO phase-tuning word using an iterative shift-add multiplier, and announces each new word with a one-cycle strobe.

## Interface
Parameters:
- `FREQ_W`, 32: width of the frequency register, in Hz.
- `F_INIT`, 7_100_000: frequency loaded at reset.
- `F_MIN`, 100_000: lower clamp limit.
- `F_MAX`, 30_000_000: upper clamp limit.
- `TW_K`, 17_592_186: round(2^(32+TW_FRAC)/f_clk) for a 16 MHz clock; 25 bits.
- `TW_FRAC`, 16: fractional bits of `TW_K`.

Ports:
- `aclk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock aclk.
- `fq_inc`  in  8  signed two's-complement detent count since the last poll.
- `in_valid`  in  1  dial output-valid level; a new value is present on each 0→1 transition.
- `step_btn`  in  1  debounced single-cycle pulse that advances the step size.
- `freq_hz`  out  FREQ_W  current tuned frequency.
- `step_idx`  out  3  current step index, 0..5.
- `tw`  out  32  NCO phase-tuning word.
- `tw_valid`  out  1  one-cycle strobe when `tw` updates.
- `busy`  out  1  high while not in IDLE.

## Operation
Input handling:
- `in_valid` is registered. An update request is the rising edge (prev=0, cur=1). A held-high level is never re-consumed.
- A request with `fq_inc`==0 is discarded: no state change, no `tw_valid`.

Step size:
- Step table indexed by `step_idx`: 1, 10, 100, 1_000, 10_000, 100_000 Hz.
- Each `step_btn` pulse increments `step_idx`, wrapping 5→0.
- If `step_btn` and an update request occur in the same cycle, the update uses the old step.

State machine:
- IDLE: on a nonzero request, latch `fq_inc` and the current step, then go to APPLY.
- APPLY (1 cycle): compute delta = sext(`fq_inc`) × step in a signed FREQ_W+2-bit domain. Compute sum = `freq_hz` + delta. Write `freq_hz` = clamp(sum, `F_MIN`, `F_MAX`). Load the multiplier and go to MUL.
- MUL (FREQ_W cycles): shift-add of `freq_hz` × `TW_K` into a 57-bit accumulator, one multiplier bit per cycle, LSB first. Then go to DONE.
- DONE (1 cycle): `tw` = accumulator[TW_FRAC+31:TW_FRAC], with the upper bits truncated. Assert `tw_valid`=1. Return to IDLE.

Requests arriving while busy:
- A rising edge seen while not in IDLE is added to a one-deep pending register. The addition saturates to [-128, +127].
- The pending register is captured with the step in effect at the time of capture.
- On return to IDLE, a nonzero pending value is processed exactly like a fresh request, and the pending register is cleared.
- A request arriving in the same cycle that DONE→IDLE occurs is merged into the pending register before it is consumed.

Reset:
- Registered reset values: `freq_hz`=`F_INIT`, `step_idx`=3 (1 kHz), `tw`=0, `tw_valid`=0, pending=0, edge register=0.
- After reset the state is APPLY with delta forced to 0, so `busy`=1. This initial pass computes `tw` for `F_INIT` automatically.
- Reset mid-operation (any state) aborts the operation: the in-flight result and any pending request are discarded, and the block re-initialises as above.

## Timing
- Request sampled at edge E → `freq_hz` updated at E+1 → MUL spans E+2..E+FREQ_W+1 → `tw`/`tw_valid` visible after edge E+FREQ_W+2 (34 cycles with defaults).
- `tw_valid` is high for exactly 1 cycle per accepted nonzero request. `tw` holds its value between strobes.
- `busy` is high from E+1 through the DONE cycle inclusive.
- Reset release at edge R → first `tw_valid` after edge R+FREQ_W+2.
- Throughput is 1 update per FREQ_W+3 cycles. This is far below the dial poll rate (≥1.6M cycles), so pending saturation is a corner case only.

## Test plan
- Reset, no input → `freq_hz`=7_100_000, `step_idx`=3. After 34 cycles `tw_valid`=1 and `tw`=(7_100_000×17_592_186)>>16, checked bit-exact against the model.
- Step 1_000, `fq_inc`=+3 with an `in_valid` 0→1 edge → `freq_hz`=7_103_000 one cycle later; a single `tw_valid` strobe 34 cycles after the sampled edge. Holding `in_valid` high produces no further strobes.
- Step 100_000 (two `step_btn` pulses), `fq_inc`=-128 (0x80) → clamped `freq_hz`=100_000. Then `fq_inc`=+127 repeated until `freq_hz` reaches 30_000_000 and stays there.
- Clear the frequency to 1_000_000 (forced via a test sequence), then request → `tw`=268_435_455 (0x0FFF_FFFF).
- Request +5 at step 10; during MUL, apply requests +100 then +100 → pending saturates to +127. After DONE, a second pass applies +1_270 Hz, producing exactly 2 `tw_valid` strobes in total.
- `step_btn` pressed 7 times → `step_idx` sequence 4,5,0,1,2,3,4. Assert reset during MUL → `tw_valid` is suppressed, `freq_hz`=7_100_000, and the init pass reruns.
